// File: rtl/alu_ctrl_stage_pkg.sv
// Shared ALU control encoding, alu_op classes and funct3 values used by the
// ID/EX stage and by the ALU that consumes its control code.
package alu_ctrl_stage_pkg;

  typedef enum logic [3:0] {
    ALU_AND     = 4'd0,
    ALU_OR      = 4'd1,
    ALU_ADD     = 4'd2,
    ALU_SUB     = 4'd6,
    ALU_SLT     = 4'd7,
    ALU_NOR     = 4'd12,
    ALU_ILLEGAL = 4'd15
  } alu_ctrl_e;

  localparam logic [1:0] OP_LDST   = 2'b00;
  localparam logic [1:0] OP_BRANCH = 2'b01;
  localparam logic [1:0] OP_RTYPE  = 2'b10;
  localparam logic [1:0] OP_ITYPE  = 2'b11;

  localparam logic [2:0] F3_ADDSUB = 3'b000;
  localparam logic [2:0] F3_SLT    = 3'b010;
  localparam logic [2:0] F3_OR     = 3'b110;
  localparam logic [2:0] F3_AND    = 3'b111;

endpackage

// File: rtl/alu_ctrl_decode.sv
// Pure combinational decode of (alu_op, funct3, funct7[5]) into the 4-bit
// ALU control code; kept standalone so a branch/forwarding unit can reuse it.
module alu_ctrl_decode
  import alu_ctrl_stage_pkg::*;
(
  input  logic [1:0] alu_op_i,
  input  logic [2:0] funct3_i,
  input  logic       funct7_b5_i,
  output logic [3:0] code_o
);

  alu_ctrl_e code;

  always_comb begin
    code = ALU_ILLEGAL;
    case (alu_op_i)
      OP_LDST:   code = ALU_ADD;
      OP_BRANCH: code = ALU_SUB;
      default: begin
        // R-type and I-type share funct3 decode; only R-type honours funct7[5]
        case (funct3_i)
          F3_ADDSUB: code = (alu_op_i == OP_RTYPE && funct7_b5_i) ? ALU_SUB : ALU_ADD;
          F3_AND:    code = ALU_AND;
          F3_OR:     code = ALU_OR;
          F3_SLT:    code = ALU_SLT;
          default:   code = ALU_ILLEGAL;
        endcase
      end
    endcase
  end

  assign code_o = code;

endmodule

// File: rtl/alu_ctrl_stage.sv
// Registered ID/EX stage feeding the ALU: decode, operand-b select, and
// hazard-unit stall/flush handling, plus a saturating stalled-cycle counter.
module alu_ctrl_stage
  import alu_ctrl_stage_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             valid_in,
  input  logic [1:0]       alu_op,
  input  logic [2:0]       funct3,
  input  logic [6:0]       funct7,
  input  logic             alu_src,
  input  logic [XLEN-1:0]  rs1_data,
  input  logic [XLEN-1:0]  rs2_data,
  input  logic [XLEN-1:0]  imm,
  input  logic             stall,
  input  logic             flush,
  output logic [3:0]       alu_control,
  output logic [XLEN-1:0]  a,
  output logic [XLEN-1:0]  b,
  output logic             valid_out,
  output logic             illegal,
  output logic [CNT_W-1:0] stall_cnt
);

  logic [3:0]       code_dec;
  logic             illegal_dec;
  logic             unused_funct7;

  logic [3:0]       ctrl_q,    ctrl_d;
  logic [XLEN-1:0]  a_q,       a_d;
  logic [XLEN-1:0]  b_q,       b_d;
  logic             valid_q,   valid_d;
  logic             illegal_q, illegal_d;
  logic [CNT_W-1:0] cnt_q,     cnt_d;

  assign unused_funct7 = ^{funct7[6], funct7[4:0]};

  alu_ctrl_decode u_decode (
    .alu_op_i    (alu_op),
    .funct3_i    (funct3),
    .funct7_b5_i (funct7[5]),
    .code_o      (code_dec)
  );

  assign illegal_dec = valid_in && (code_dec == ALU_ILLEGAL);

  always_comb begin
    ctrl_d    = ctrl_q;
    a_d       = a_q;
    b_d       = b_q;
    valid_d   = valid_q;
    illegal_d = illegal_q;
    if (flush) begin
      ctrl_d    = ALU_ADD;
      a_d       = '0;
      b_d       = '0;
      valid_d   = 1'b0;
      illegal_d = 1'b0;
    end else if (!stall) begin
      ctrl_d    = code_dec;
      a_d       = rs1_data;
      b_d       = alu_src ? imm : rs2_data;
      valid_d   = valid_in && !illegal_dec;
      illegal_d = illegal_dec;
    end
  end

  // Counts only cycles where a live instruction is actually being held
  always_comb begin
    cnt_d = cnt_q;
    if (stall && !flush && valid_q && (cnt_q != {CNT_W{1'b1}}))
      cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ctrl_q    <= ALU_ADD;
      a_q       <= '0;
      b_q       <= '0;
      valid_q   <= 1'b0;
      illegal_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      ctrl_q    <= ctrl_d;
      a_q       <= a_d;
      b_q       <= b_d;
      valid_q   <= valid_d;
      illegal_q <= illegal_d;
      cnt_q     <= cnt_d;
    end
  end

  assign alu_control = ctrl_q;
  assign a           = a_q;
  assign b           = b_q;
  assign valid_out   = valid_q;
  assign illegal     = illegal_q;
  assign stall_cnt   = cnt_q;

endmodule

// File: tb/tb_alu_ctrl_stage.sv
// Bench for alu_ctrl_stage: decode vector table through a scoreboard queue,
// then stall/flush, async reset and counter saturation sequences.
module tb_alu_ctrl_stage;

  localparam int XLEN  = 32;
  localparam int CNT_W = 4;

  logic             clk;
  logic             reset_n = 1'b1;
  logic             valid_in;
  logic [1:0]       alu_op;
  logic [2:0]       funct3;
  logic [6:0]       funct7;
  logic             alu_src;
  logic [XLEN-1:0]  rs1_data, rs2_data, imm;
  logic             stall, flush;
  logic [3:0]       alu_control;
  logic [XLEN-1:0]  a, b;
  logic             valid_out, illegal;
  logic [CNT_W-1:0] stall_cnt;

  typedef struct {
    logic        vin;
    logic [1:0]  op;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic        src;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] im;
    logic [3:0]  ectrl;
    logic [31:0] eb;
    logic        ev;
    logic        eil;
  } vec_t;

  typedef struct {
    logic [3:0]  ctrl;
    logic [31:0] ea;
    logic [31:0] eb;
    logic        ev;
    logic        eil;
  } exp_t;

  vec_t vecs[$];
  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  alu_ctrl_stage #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .valid_in    (valid_in),
    .alu_op      (alu_op),
    .funct3      (funct3),
    .funct7      (funct7),
    .alu_src     (alu_src),
    .rs1_data    (rs1_data),
    .rs2_data    (rs2_data),
    .imm         (imm),
    .stall       (stall),
    .flush       (flush),
    .alu_control (alu_control),
    .a           (a),
    .b           (b),
    .valid_out   (valid_out),
    .illegal     (illegal),
    .stall_cnt   (stall_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  task automatic chk_out(input string nm, input exp_t e);
    chk({nm, ".ctrl"},    {28'd0, alu_control}, {28'd0, e.ctrl});
    chk({nm, ".a"},       a, e.ea);
    chk({nm, ".b"},       b, e.eb);
    chk({nm, ".valid"},   {31'd0, valid_out}, {31'd0, e.ev});
    chk({nm, ".illegal"}, {31'd0, illegal}, {31'd0, e.eil});
  endtask

  task automatic drive(input vec_t v);
    valid_in = v.vin;
    alu_op   = v.op;
    funct3   = v.f3;
    funct7   = v.f7;
    alu_src  = v.src;
    rs1_data = v.rs1;
    rs2_data = v.rs2;
    imm      = v.im;
  endtask

  task automatic chk_reset_state(input string nm);
    chk_out(nm, '{4'd2, 32'd0, 32'd0, 1'b0, 1'b0});
    chk({nm, ".cnt"}, {28'd0, stall_cnt}, 32'd0);
  endtask

  initial begin
    vec_t v;
    exp_t e;
    int   n;

    //           vin  op     f3      f7     src  rs1           rs2           imm           ctrl  eb            ev    eil
    vecs.push_back('{1'b1, 2'b00, 3'b000, 7'h00, 1'b0, 32'h0000000A, 32'h00000003, 32'h000000FC, 4'd2,  32'h00000003, 1'b1, 1'b0});
    vecs.push_back('{1'b1, 2'b01, 3'b000, 7'h00, 1'b0, 32'h00000005, 32'h00000007, 32'h00000000, 4'd6,  32'h00000007, 1'b1, 1'b0});
    vecs.push_back('{1'b1, 2'b10, 3'b000, 7'h00, 1'b0, 32'h0000000A, 32'h00000003, 32'h00000000, 4'd2,  32'h00000003, 1'b1, 1'b0});
    vecs.push_back('{1'b1, 2'b10, 3'b000, 7'h20, 1'b0, 32'h0000000A, 32'h00000003, 32'h00000000, 4'd6,  32'h00000003, 1'b1, 1'b0});
    vecs.push_back('{1'b1, 2'b10, 3'b111, 7'h00, 1'b0, 32'h12345678, 32'h0F0F0F0F, 32'h00000000, 4'd0,  32'h0F0F0F0F, 1'b1, 1'b0});
    vecs.push_back('{1'b1, 2'b10, 3'b110, 7'h00, 1'b0, 32'h80000000, 32'h00000001, 32'h00000000, 4'd1,  32'h00000001, 1'b1, 1'b0});
    vecs.push_back('{1'b1, 2'b10, 3'b010, 7'h00, 1'b0, 32'hFFFFFFFF, 32'h00000002, 32'h00000000, 4'd7,  32'h00000002, 1'b1, 1'b0});
    vecs.push_back('{1'b1, 2'b10, 3'b001, 7'h00, 1'b0, 32'h00000011, 32'h00000022, 32'h00000000, 4'd15, 32'h00000022, 1'b0, 1'b1});
    vecs.push_back('{1'b1, 2'b11, 3'b000, 7'h20, 1'b1, 32'h00000001, 32'h00000002, 32'hFFFFFFFC, 4'd2,  32'hFFFFFFFC, 1'b1, 1'b0});
    vecs.push_back('{1'b1, 2'b11, 3'b111, 7'h00, 1'b1, 32'h000000FF, 32'hDEADBEEF, 32'h000000F0, 4'd0,  32'h000000F0, 1'b1, 1'b0});
    vecs.push_back('{1'b1, 2'b11, 3'b110, 7'h20, 1'b1, 32'h00000100, 32'hDEADBEEF, 32'h00000001, 4'd1,  32'h00000001, 1'b1, 1'b0});
    vecs.push_back('{1'b1, 2'b11, 3'b010, 7'h00, 1'b1, 32'h00000003, 32'hDEADBEEF, 32'h00000004, 4'd7,  32'h00000004, 1'b1, 1'b0});
    vecs.push_back('{1'b1, 2'b11, 3'b101, 7'h00, 1'b1, 32'h00000009, 32'h00000000, 32'h00000005, 4'd15, 32'h00000005, 1'b0, 1'b1});
    vecs.push_back('{1'b0, 2'b10, 3'b001, 7'h00, 1'b0, 32'h00000033, 32'h00000044, 32'h00000000, 4'd15, 32'h00000044, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 2'b10, 3'b000, 7'h20, 1'b0, 32'h00000055, 32'h00000066, 32'h00000000, 4'd6,  32'h00000066, 1'b0, 1'b0});
    vecs.push_back('{1'b1, 2'b10, 3'b100, 7'h00, 1'b0, 32'h00000077, 32'h00000088, 32'h00000000, 4'd15, 32'h00000088, 1'b0, 1'b1});
    vecs.push_back('{1'b1, 2'b00, 3'b111, 7'h20, 1'b1, 32'h00001000, 32'h00000000, 32'h00000010, 4'd2,  32'h00000010, 1'b1, 1'b0});
    vecs.push_back('{1'b1, 2'b01, 3'b001, 7'h00, 1'b0, 32'h00000020, 32'h00000030, 32'h00000000, 4'd6,  32'h00000030, 1'b1, 1'b0});

    drive('{1'b0, 2'b00, 3'b000, 7'h00, 1'b0, 32'd0, 32'd0, 32'd0, 4'd0, 32'd0, 1'b0, 1'b0});
    stall = 1'b0;
    flush = 1'b0;

    #2 reset_n = 1'b0;
    #1 chk_reset_state("por");
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk_out($sformatf("vec%0d", i - 1), e);
      end
      drive(vecs[i]);
      exp_q.push_back('{vecs[i].ectrl, vecs[i].rs1, vecs[i].eb, vecs[i].ev, vecs[i].eil});
    end
    @(negedge clk);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk_out($sformatf("vec%0d", vecs.size() - 1), e);
    end
    chk("sb_empty", exp_q.size(), 32'd0);
    chk("cnt_no_stall", {28'd0, stall_cnt}, 32'd0);

    // Async reset in the middle of a cycle, with a live instruction loaded
    @(posedge clk);
    #3 reset_n = 1'b0;
    #1 chk_reset_state("async_rst");
    @(negedge clk);
    reset_n = 1'b1;

    // Stall holds AND for 3 cycles, then flush beats stall
    v = '{1'b1, 2'b10, 3'b111, 7'h00, 1'b0, 32'h00000011, 32'h00000022, 32'd0, 4'd0, 32'd0, 1'b0, 1'b0};
    drive(v);
    @(negedge clk);
    chk_out("and_load", '{4'd0, 32'h11, 32'h22, 1'b1, 1'b0});
    drive('{1'b1, 2'b01, 3'b000, 7'h00, 1'b1, 32'h99, 32'h98, 32'h97, 4'd0, 32'd0, 1'b0, 1'b0});
    stall = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      chk_out($sformatf("stall%0d", i), '{4'd0, 32'h11, 32'h22, 1'b1, 1'b0});
      chk($sformatf("stall%0d.cnt", i), {28'd0, stall_cnt}, i);
    end
    flush = 1'b1;
    @(negedge clk);
    chk_out("flush", '{4'd2, 32'd0, 32'd0, 1'b0, 1'b0});
    chk("flush.cnt", {28'd0, stall_cnt}, 32'd3);
    flush = 1'b0;
    @(negedge clk);
    chk("bubble_stall.cnt", {28'd0, stall_cnt}, 32'd3);
    chk("bubble_stall.valid", {31'd0, valid_out}, 32'd0);
    stall = 1'b0;

    // Saturation with CNT_W=4, then reset while stalled drops the instruction
    @(negedge clk);
    #1 reset_n = 1'b0;
    #1 chk_reset_state("pre_sat_rst");
    reset_n = 1'b1;
    drive('{1'b1, 2'b11, 3'b000, 7'h00, 1'b1, 32'h5, 32'h0, 32'h7, 4'd0, 32'd0, 1'b0, 1'b0});
    @(negedge clk);
    chk_out("sat_load", '{4'd2, 32'h5, 32'h7, 1'b1, 1'b0});
    stall = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      n = (i > 15) ? 15 : i;
      chk($sformatf("sat%0d.cnt", i), {28'd0, stall_cnt}, n);
    end
    chk_out("sat_held", '{4'd2, 32'h5, 32'h7, 1'b1, 1'b0});
    #2 reset_n = 1'b0;
    #1 chk_reset_state("stall_rst");
    @(negedge clk);
    reset_n = 1'b1;
    valid_in = 1'b0;
    @(negedge clk);
    chk("stall_rst.valid", {31'd0, valid_out}, 32'd0);
    chk("stall_rst.cnt", {28'd0, stall_cnt}, 32'd0);
    stall = 1'b0;
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_ctrl_stage.md
Name: alu_ctrl_stage

Overview:
Registered ID/EX boundary stage that drives the ALU. It is the producer side of the 4-bit alu_control / a / b interface the ALU consumes.
- Decodes alu_op, funct3 and funct7 into the ALU's control encoding.
- Selects operand b from rs2 or the immediate.
- Presents all ALU inputs from flops, with stall (hold) and flush (bubble) control from the hazard unit.

Parameters:
XLEN, 32, operand width for a, b, rs1_data, rs2_data, imm.
CNT_W, 16, width of the saturating stall-cycle counter.

Ports:
clk  input  1  rising-edge clock
reset_n  input  1  asynchronous, active-low reset
valid_in  input  1  ID-stage instruction valid
alu_op  input  2  00 load/store, 01 branch, 10 R-type, 11 I-type arith
funct3  input  3  instruction funct3
funct7  input  7  instruction funct7 (only bit 5 used)
alu_src  input  1  1: b = imm, 0: b = rs2_data
rs1_data  input  XLEN  register operand 1
rs2_data  input  XLEN  register operand 2
imm  input  XLEN  sign-extended immediate
stall  input  1  hold all stage registers
flush  input  1  replace stage contents with a bubble
alu_control  output  4  registered ALU control code
a  output  XLEN  registered operand a
b  output  XLEN  registered operand b
valid_out  output  1  stage holds a live instruction
illegal  output  1  decoded op unsupported; valid_out forced 0
stall_cnt  output  CNT_W  saturating count of stalled cycles with valid_out=1

Behaviour:
Control codes:
- AND=0, OR=1, ADD=2, SUB=6, SLT=7, NOR=12 (reserved, never generated).
- ILLEGAL=15; the ALU outputs 0 for this code.

Decode (combinational, in front of the flops):
- alu_op=00 -> ADD.
- alu_op=01 -> SUB.
- alu_op=10:
  - funct3=000 with funct7[5]=0 -> ADD; with funct7[5]=1 -> SUB.
  - funct3=111 -> AND; 110 -> OR; 010 -> SLT.
  - any other funct3 -> ILLEGAL.
- alu_op=11:
  - funct3=000 -> ADD, funct7 ignored.
  - funct3=111 -> AND; 110 -> OR; 010 -> SLT.
  - any other funct3 -> ILLEGAL.

Operands:
- a_next = rs1_data.
- b_next = alu_src ? imm : rs2_data.
- No width change; no sign handling in this stage.

Reset:
- reset_n low, asynchronous: alu_control=2, a=0, b=0, valid_out=0, illegal=0, stall_cnt=0.
- Reset release takes effect at the next clk edge.

Update priority on each rising clk edge:
1. flush=1 -> bubble: alu_control=2, a=0, b=0, valid_out=0, illegal=0. Flush wins over stall.
2. Else stall=1 -> all stage registers hold.
3. Else load:
   - alu_control, a, b take the decoded values.
   - illegal = valid_in & (code==ILLEGAL).
   - valid_out = valid_in & ~illegal_next.

Invalid input:
- valid_in=0 on load: a, b, alu_control still load the decoded values; valid_out=0, illegal=0.

Latency:
- Exactly 1 cycle from ID inputs to outputs when not stalled.
- No combinational path from any input to any output.

stall_cnt:
- Increments when stall=1, flush=0 and valid_out=1.
- Saturates at 2^CNT_W-1; no wrap.
- Cleared only by reset.

Mid-stall reset: reset clears the stage. A held instruction is dropped, not replayed.

Decomposition:
- Shared package/header: ALU control code constants (AND, OR, ADD, SUB, SLT, NOR, ILLEGAL), alu_op encodings, funct3 constants. The ALU and this stage both include it.
- Sub-module alu_ctrl_decode: pure combinational decode of (alu_op, funct3, funct7[5]) to a 4-bit code. Reusable by a future forwarding/branch unit.
- Counter and register file stay in the top module.

Test Plan:
1. Reset: hold reset_n=0 mid-cycle -> outputs go to alu_control=2, a=b=0, valid_out=0, stall_cnt=0 immediately, without a clk edge.
2. R-type SUB: valid_in=1, alu_op=10, funct3=000, funct7=0100000, rs1=0x0000000A, rs2=0x00000003, alu_src=0 -> next cycle alu_control=6, a=0xA, b=0x3, valid_out=1.
3. I-type ADD with immediate: alu_op=11, funct3=000, funct7=0100000, alu_src=1, imm=0xFFFFFFFC -> alu_control=2, b=0xFFFFFFFC. funct7 must be ignored.
4. Illegal decode: alu_op=10, funct3=001 -> alu_control=15, illegal=1, valid_out=0.
5. Stall then flush:
   - Load AND (funct3=111) and hold stall=1 for 3 cycles -> outputs frozen, stall_cnt=3.
   - Assert stall=1 with flush=1 -> bubble: alu_control=2, valid_out=0; stall_cnt stays 3.
6. Saturation: CNT_W=4, valid instruction held with stall=1 for 20 cycles -> stall_cnt reaches 15 and stays at 15.
